// File: rtl/mem_boot_loader_pkg.sv
// Shared types and command codes for the byte-stream boot loader.
// Used by mem_boot_loader and its testbench.
package mem_boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam logic [7:0] CMD_IMEM = 8'h49;
    localparam logic [7:0] CMD_DMEM = 8'h44;
    localparam logic [7:0] CMD_GO   = 8'h47;

    function automatic logic is_load(input logic [7:0] cmd);
        return (cmd == CMD_IMEM) || (cmd == CMD_DMEM);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles four stream bytes MSB-first into a 32-bit word.
// word/word_done are valid combinationally in the cycle the 4th byte shifts in.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    // Shift register and byte counter; cleared on reset or frame start
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[15:0], in_byte};
            cnt <= cnt + 2'd1;
        end
    end

    assign word      = {sr, in_byte};
    assign word_done = shift && (cnt == 2'd3);

endmodule

// File: rtl/mem_boot_loader.sv
// Framed byte-stream loader for instruction memory and data RAM.
// Optional checksum byte per I/D frame: define BOOT_LOADER_CHECKSUM_EN.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit     CSUM_EN = 1'b1;
    localparam state_t END_ST  = ST_CSUM;
`else
    localparam bit     CSUM_EN = 1'b0;
    localparam state_t END_ST  = ST_IDLE;
`endif

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [7:0]        addr_hi;
    logic [7:0]        cnt_hi;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       cnt;
    logic [15:0]       cnt_in;
    logic              sel_imem;
    logic [7:0]        csum;
    logic [7:0]        csum_nxt;
    logic [31:0]       word;
    logic              word_done;

    assign in_ready = !rst && (state != ST_RUN) && (state != ST_ERR);
    assign accept   = in_valid && in_ready;
    assign cnt_in   = {cnt_hi, in_data};
    assign csum_nxt = csum + in_data;
    assign cpu_rst  = (state != ST_RUN);
    assign err      = (state == ST_ERR);

    byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept && (state == ST_IDLE)),
        .shift     (accept && (state == ST_DATA)),
        .in_byte   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; only an accepted byte moves the FSM
    always_comb begin
        state_nxt = state;
        if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (is_load(in_data))        state_nxt = ST_ADDR_HI;
                    else if (in_data == CMD_GO)  state_nxt = ST_RUN;
                    else                         state_nxt = ST_ERR;
                end
                ST_ADDR_HI: state_nxt = ST_ADDR_LO;
                ST_ADDR_LO: state_nxt = ST_CNT_HI;
                ST_CNT_HI:  state_nxt = ST_CNT_LO;
                ST_CNT_LO: begin
                    if (cnt_in == 16'd0) state_nxt = END_ST;
                    else                 state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (word_done && cnt == 16'd1) state_nxt = END_ST;
                end
                ST_CSUM: begin
                    if (csum_nxt == 8'h00) state_nxt = ST_IDLE;
                    else                   state_nxt = ST_ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Frame fields, counters, checksum and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hi   <= '0;
            cnt_hi    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            sel_imem  <= 1'b0;
            csum      <= '0;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            done    <= 1'b0;
            if (accept) begin
                csum <= csum_nxt;
                unique case (state)
                    ST_IDLE: begin
                        csum     <= in_data;
                        sel_imem <= (in_data == CMD_IMEM);
                    end
                    ST_ADDR_HI: addr_hi <= in_data;
                    ST_ADDR_LO: ptr <= ADDR_W'({addr_hi, in_data});
                    ST_CNT_HI:  cnt_hi <= in_data;
                    ST_CNT_LO: begin
                        cnt  <= cnt_in;
                        done <= !CSUM_EN && (cnt_in == 16'd0);
                    end
                    ST_DATA: begin
                        if (word_done) begin
                            imem_we   <= sel_imem;
                            dmem_we   <= !sel_imem;
                            mem_addr  <= ptr;
                            mem_wdata <= word;
                            ptr       <= ptr + ADDR_W'(1);
                            cnt       <= cnt - 16'd1;
                            done      <= !CSUM_EN && (cnt == 16'd1);
                        end
                    end
                    ST_CSUM: done <= (csum_nxt == 8'h00);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Self-checking bench for mem_boot_loader: directed timing, table vectors,
// random frames against a write-list model. Honours BOOT_LOADER_CHECKSUM_EN.
module tb_mem_boot_loader;
    import mem_boot_loader_pkg::*;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we, dmem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst, done, err;

    mem_boot_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .dmem_we(dmem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        i;
        logic        d;
        logic        dn;
        logic [9:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] base;
        int          n;
        logic [31:0] w0, w1;
        int          a0, a1;
    } vec_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  both_hi = 0;
    logic [7:0]  tsum;
    logic [31:0] fw[4];

    // Record every strobe / done cycle seen on the write port
    always @(negedge clk) begin
        if (imem_we && dmem_we) both_hi++;
        if (imem_we || dmem_we || done)
            obs_q.push_back('{imem_we, dmem_we, done,
                (imem_we | dmem_we) ? mem_addr : 10'd0,
                (imem_we | dmem_we) ? mem_wdata : 32'd0});
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        tick(gap);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: byte %0h not accepted", b);
        end else begin
            tick(1);
            tsum = tsum + b;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] base,
                              input int n, input int maxgap);
        logic [15:0] nn;
        nn   = 16'(n);
        tsum = 8'h00;
        send_byte(cmd, $urandom_range(0, maxgap));
        send_byte(base[15:8], $urandom_range(0, maxgap));
        send_byte(base[7:0], $urandom_range(0, maxgap));
        send_byte(nn[15:8], $urandom_range(0, maxgap));
        send_byte(nn[7:0], $urandom_range(0, maxgap));
        for (int k = 0; k < n; k++)
            for (int j = 3; j >= 0; j--)
                send_byte(fw[k][8*j +: 8], $urandom_range(0, maxgap));
        if (CS) send_byte(8'h00 - tsum, $urandom_range(0, maxgap));
    endtask

    task automatic expect_ev(input logic [7:0] cmd, input int addr,
                             input logic [31:0] data, input logic dn);
        exp_q.push_back('{cmd == CMD_IMEM, cmd == CMD_DMEM, dn,
                          10'(addr), data});
    endtask

    task automatic expect_done_only();
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 10'd0, 32'd0});
    endtask

    // Reference: word k of a frame lands at (base + k) mod 1024
    task automatic model_frame(input logic [7:0] cmd, input logic [15:0] base,
                               input int n);
        for (int k = 0; k < n; k++)
            expect_ev(cmd, (int'(base) + k) % 1024, fw[k],
                      !CS && (k == n - 1));
        if (n == 0 || CS) expect_done_only();
    endtask

    task automatic check_events(input string name);
        ev_t o, e;
        tick(3);
        chk({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk(name, 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        obs_q.delete();
        exp_q.delete();
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'h49, 16'h0000, 2, 32'h20080005, 32'hAC090004, 0, 1};
        vt[1] = '{8'h44, 16'h00FA, 1, 32'hDEADBEEF, 32'h0, 250, 0};
        vt[2] = '{8'h49, 16'h03FF, 2, 32'h11111111, 32'h22222222, 1023, 0};
        vt[3] = '{8'h44, 16'h1405, 2, 32'hCAFEF00D, 32'h0BADBEEF, 5, 6};
        vt[4] = '{8'h49, 16'h0123, 0, 32'h0, 32'h0, 0, 0};
        vt[5] = '{8'h44, 16'hFFFF, 2, 32'h01020304, 32'hA5A5A5A5, 1023, 0};

        #1;
        tick(2);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_dmem_we", 64'(dmem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back imem frame with cycle-exact strobe checks
        tsum = 8'h00;
        send_byte(8'h49, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        chk("w0_imem_we", 64'(imem_we), 64'd1);
        chk("w0_dmem_we", 64'(dmem_we), 64'd0);
        chk("w0_addr", 64'(mem_addr), 64'd0);
        chk("w0_data", 64'(mem_wdata), 64'h20080005);
        chk("w0_done", 64'(done), 64'd0);
        send_byte(8'hAC, 0); send_byte(8'h09, 0); send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        chk("w1_imem_we", 64'(imem_we), 64'd1);
        chk("w1_addr", 64'(mem_addr), 64'd1);
        chk("w1_data", 64'(mem_wdata), 64'hAC090004);
        chk("w1_done", 64'(done), 64'(!CS));
        chk("w1_cpu_rst", 64'(cpu_rst), 64'd1);
        if (CS) begin
            send_byte(8'h00 - tsum, 0);
            chk("w1_csum_done", 64'(done), 64'd1);
        end
        tick(2);
        obs_q.delete();

        // Table vectors with random stalls
        foreach (vt[v]) begin
            fw[0] = vt[v].w0;
            fw[1] = vt[v].w1;
            send_frame(vt[v].cmd, vt[v].base, vt[v].n, 2);
            if (vt[v].n > 0)
                expect_ev(vt[v].cmd, vt[v].a0, vt[v].w0,
                          !CS && vt[v].n == 1);
            if (vt[v].n > 1)
                expect_ev(vt[v].cmd, vt[v].a1, vt[v].w1, !CS);
            if (vt[v].n == 0 || CS) expect_done_only();
            check_events("vec");
        end

        // Random frames against the write-list model
        for (int r = 0; r < 25; r++) begin
            logic [7:0]  c;
            logic [15:0] b;
            int          n;
            c = ($urandom_range(0, 1) == 1) ? CMD_IMEM : CMD_DMEM;
            b = 16'($urandom);
            n = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) fw[k] = $urandom;
            send_frame(c, b, n, $urandom_range(0, 2));
            model_frame(c, b, n);
            check_events("rand");
        end

        // dmem word then GO
        fw[0] = 32'hDEADBEEF;
        send_frame(CMD_DMEM, 16'h00FA, 1, 0);
        expect_ev(CMD_DMEM, 250, 32'hDEADBEEF, !CS);
        if (CS) expect_done_only();
        check_events("dmem250");
        chk("pre_go_cpu_rst", 64'(cpu_rst), 64'd1);
        send_byte(CMD_GO, 0);
        chk("go_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("go_in_ready", 64'(in_ready), 64'd0);
        in_data  = CMD_IMEM;
        in_valid = 1'b1;
        tick(5);
        in_valid = 1'b0;
        chk("run_in_ready", 64'(in_ready), 64'd0);
        chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
        check_events("run_quiet");

        // Illegal command is terminal until reset
        do_reset();
        send_byte(8'h55, 0);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_ready", 64'(in_ready), 64'd0);
        chk("bad_cpu_rst", 64'(cpu_rst), 64'd1);
        tick(4);
        chk("bad_err_hold", 64'(err), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_ready_low", 64'(in_ready), 64'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("clr_err", 64'(err), 64'd0);
        chk("clr_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("clr_ready", 64'(in_ready), 64'd1);

        // Reset mid-word discards the partial word
        obs_q.delete();
        tsum = 8'h00;
        send_byte(8'h49, 1); send_byte(8'h00, 1); send_byte(8'h10, 1);
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check_events("partial");
        fw[0] = 32'h12345678;
        send_frame(CMD_DMEM, 16'h0010, 1, 1);
        expect_ev(CMD_DMEM, 16, 32'h12345678, !CS);
        if (CS) expect_done_only();
        check_events("fresh");

        // Empty frame: done timing and checksum acceptance
        do_reset();
        tsum = 8'h00;
        send_byte(8'h49, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        chk("n0_no_done_yet", 64'(done), 64'd0);
        send_byte(8'hB7, 0);
        chk("csum_ok_done", 64'(done), 64'd1);
        chk("csum_ok_err", 64'(err), 64'd0);
        send_byte(8'h49, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hB8, 0);
        chk("csum_bad_err", 64'(err), 64'd1);
        chk("csum_bad_done", 64'(done), 64'd0);
`else
        chk("n0_done", 64'(done), 64'd1);
        chk("n0_ready", 64'(in_ready), 64'd1);
        tick(1);
        chk("n0_done_pulse", 64'(done), 64'd0);
`endif

        chk("one_hot_strobe", 64'(both_hi), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
